// File: rtl/gen_channel_elastic_pipe.sv
// Multi-channel elastic register pipeline: each channel is an independent DEPTH-stage
// valid/ready pipe with per-channel flush, occupancy and output-transfer counter.
module gen_channel_elastic_pipe #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 3,
    localparam int unsigned OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CHANNELS-1:0]             in_valid,
    output logic [NUM_CHANNELS-1:0]             in_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_W-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]             out_valid,
    input  logic [NUM_CHANNELS-1:0]             out_ready,
    output logic [NUM_CHANNELS-1:0][DATA_W-1:0] out_data,
    input  logic [NUM_CHANNELS-1:0]             flush,
    output logic [NUM_CHANNELS-1:0][OCC_W-1:0]  occupancy,
    output logic [NUM_CHANNELS-1:0][15:0]       xfer_count
);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [DEPTH-1:0]             valid_q;
        logic [DEPTH-1:0][DATA_W-1:0] data_q;
        logic [DEPTH-1:0]             stage_rdy;
        logic [DEPTH-1:0]             prev_valid;
        logic [DEPTH-1:0][DATA_W-1:0] prev_data;
        logic [OCC_W-1:0]             occ;
        logic [15:0]                  cnt_q;
        logic                         out_xfer;

        // Ready ripples back from the output: a stage can take a word if it is empty
        // or the stage after it is moving this cycle.
        always_comb begin
            logic rdy_chain;
            rdy_chain = out_ready[c];
            stage_rdy = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                rdy_chain    = !valid_q[k] || rdy_chain;
                stage_rdy[k] = rdy_chain;
            end
        end

        always_comb begin
            prev_valid    = '0;
            prev_data     = '0;
            prev_valid[0] = in_valid[c];
            prev_data[0]  = in_data[c];
            for (int k = 1; k < DEPTH; k++) begin
                prev_valid[k] = valid_q[k-1];
                prev_data[k]  = data_q[k-1];
            end
        end

        always_comb begin
            occ = '0;
            for (int k = 0; k < DEPTH; k++) begin
                occ = occ + OCC_W'(valid_q[k]);
            end
        end

        assign in_ready[c]   = stage_rdy[0] && !flush[c];
        assign out_valid[c]  = valid_q[DEPTH-1] && !flush[c];
        assign out_data[c]   = data_q[DEPTH-1];
        assign occupancy[c]  = occ;
        assign xfer_count[c] = cnt_q;
        assign out_xfer      = out_valid[c] && out_ready[c];

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
                cnt_q   <= '0;
            end else if (flush[c]) begin
                valid_q <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (stage_rdy[k]) begin
                        valid_q[k] <= prev_valid[k];
                        // Bubbles leave the data register untouched.
                        if (prev_valid[k]) begin
                            data_q[k] <= prev_data[k];
                        end
                    end
                end
                if (out_xfer) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_channel_elastic_pipe.sv
// Directed and randomised checks for gen_channel_elastic_pipe at default parameters.
module tb_gen_channel_elastic_pipe;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int D   = 3;
    localparam int OW  = $clog2(D + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NCH-1:0]          in_valid;
    logic [NCH-1:0]          in_ready;
    logic [NCH-1:0][DW-1:0]  in_data;
    logic [NCH-1:0]          out_valid;
    logic [NCH-1:0]          out_ready;
    logic [NCH-1:0][DW-1:0]  out_data;
    logic [NCH-1:0]          flush;
    logic [NCH-1:0][OW-1:0]  occupancy;
    logic [NCH-1:0][15:0]    xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gen_channel_elastic_pipe #(
        .NUM_CHANNELS(NCH),
        .DATA_W      (DW),
        .DEPTH       (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .xfer_count(xfer_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        flush     = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = '1;
        #1;
        n_tests++;
        if (out_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_tests++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        n_tests++;
        if (occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_occupancy: got %h want 0", occupancy);
        end
        n_tests++;
        if (xfer_count !== '0) begin
            n_fail++;
            $display("FAIL reset_xfer_count: got %h want 0", xfer_count);
        end
        n_tests++;
        if (in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1111", in_ready);
        end
    endtask

    task automatic test_latency();
        logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                in_valid[0] = 1'b1;
                in_data[0]  = w[i];
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            n_tests++;
            if (i < 3) begin
                if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_fill c%0d: in_ready=%b out_valid=%b want 1/0",
                             i, in_ready[0], out_valid[0]);
                end
            end else begin
                if (out_valid[0] !== 1'b1 || out_data[0] !== w[i-3]) begin
                    n_fail++;
                    $display("FAIL latency_out c%0d: valid=%b data=%h want 1/%h",
                             i, out_valid[0], out_data[0], w[i-3]);
                end
            end
            tick();
        end
        n_tests++;
        if (out_valid[0] !== 1'b0 || xfer_count[0] !== 16'd3) begin
            n_fail++;
            $display("FAIL latency_count: valid=%b count=%0d want 0/3",
                     out_valid[0], xfer_count[0]);
        end
        n_tests++;
        if (xfer_count[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL latency_isolation: ch1 count=%0d want 0", xfer_count[1]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = a[i];
            #1;
            n_tests++;
            if (in_ready[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept c%0d: in_ready=%b want 1", i, in_ready[1]);
            end
            tick();
        end
        in_data[1] = a[3];
        #1;
        n_tests++;
        if (in_ready[1] !== 1'b0 || occupancy[1] !== 2'd3 || out_valid[1] !== 1'b1 ||
            out_data[1] !== 8'hA1) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b occ=%0d valid=%b data=%h want 0/3/1/a1",
                     in_ready[1], occupancy[1], out_valid[1], out_data[1]);
        end
        tick();
        out_ready[1] = 1'b1;
        #1;
        n_tests++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b1 || out_data[1] !== 8'hA1) begin
            n_fail++;
            $display("FAIL bp_passthrough: in_ready=%b valid=%b data=%h want 1/1/a1",
                     in_ready[1], out_valid[1], out_data[1]);
        end
        tick();
        in_valid[1] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_tests++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== a[i]) begin
                n_fail++;
                $display("FAIL bp_drain w%0d: valid=%b data=%h want 1/%h",
                         i, out_valid[1], out_data[1], a[i]);
            end
            tick();
        end
        n_tests++;
        if (out_valid[1] !== 1'b0 || xfer_count[1] !== 16'd4 || occupancy[1] !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b count=%0d occ=%0d want 0/4/0",
                     out_valid[1], xfer_count[1], occupancy[1]);
        end
    endtask

    task automatic test_flush();
        logic [7:0] cw [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        do_reset();
        out_ready[3] = 1'b1;
        in_valid[2]  = 1'b1;
        in_data[2]   = 8'hB1;
        in_valid[3]  = 1'b1;
        in_data[3]   = cw[0];
        tick();
        in_data[2] = 8'hB2;
        in_data[3] = cw[1];
        tick();
        in_valid[2] = 1'b0;
        in_data[3]  = cw[2];
        tick();
        in_data[3] = cw[3];
        #1;
        n_tests++;
        if (occupancy[2] !== 2'd2 || out_valid[2] !== 1'b1 || out_data[2] !== 8'hB1) begin
            n_fail++;
            $display("FAIL flush_pre: occ=%0d valid=%b data=%h want 2/1/b1",
                     occupancy[2], out_valid[2], out_data[2]);
        end
        flush[2]     = 1'b1;
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_data[2]   = 8'hB3;
        #1;
        n_tests++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_active: out_valid=%b in_ready=%b want 0/0",
                     out_valid[2], in_ready[2]);
        end
        n_tests++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== cw[0] || in_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_neighbour c3: valid=%b data=%h in_ready=%b want 1/c1/1",
                     out_valid[3], out_data[3], in_ready[3]);
        end
        tick();
        flush    = '0;
        in_valid = '0;
        #1;
        n_tests++;
        if (occupancy[2] !== 2'd0 || xfer_count[2] !== 16'd0 || out_valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: occ=%0d count=%0d valid=%b want 0/0/0",
                     occupancy[2], xfer_count[2], out_valid[2]);
        end
        for (int i = 1; i < 4; i++) begin
            if (i > 1) #1;
            n_tests++;
            if (out_valid[3] !== 1'b1 || out_data[3] !== cw[i]) begin
                n_fail++;
                $display("FAIL flush_neighbour w%0d: valid=%b data=%h want 1/%h",
                         i, out_valid[3], out_data[3], cw[i]);
            end
            tick();
        end
        n_tests++;
        if (xfer_count[3] !== 16'd4 || out_valid[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_neighbour_count: count=%0d valid=%b want 4/0",
                     xfer_count[3], out_valid[3]);
        end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'h61 + 8'(i);
            tick();
        end
        in_data[0] = 8'h64;
        rst        = 1'b1;
        flush      = '1;
        tick();
        rst      = 1'b0;
        flush    = '0;
        in_valid = '0;
        #1;
        n_tests++;
        if (out_valid !== '0 || out_data !== '0 || occupancy !== '0 || xfer_count !== '0 ||
            in_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_mid_state: ov=%b od=%h occ=%h cnt=%h ir=%b want 0/0/0/0/1111",
                     out_valid, out_data, occupancy, xfer_count, in_ready);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h5A;
        #1;
        n_tests++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_accept: in_ready=%b want 1", in_ready[0]);
        end
        tick();
        in_valid[0] = 1'b0;
        for (int i = 1; i < D; i++) begin
            n_tests++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_early c%0d: out_valid=%b want 0", i, out_valid[0]);
            end
            tick();
        end
        n_tests++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_mid_first: valid=%b data=%h want 1/5a", out_valid[0], out_data[0]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sb [NCH][$];
        logic [DW-1:0] exp_w;
        do_reset();
        for (int cyc = 0; cyc < 10000 + D + 2; cyc++) begin
            if (cyc < 10000) begin
                in_valid  = NCH'($urandom);
                out_ready = NCH'($urandom);
                for (int c = 0; c < NCH; c++) in_data[c] = DW'($urandom_range(0, 255));
            end else begin
                in_valid  = '0;
                out_ready = '1;
            end
            #1;
            for (int c = 0; c < NCH; c++) begin
                n_tests++;
                if (occupancy[c] !== OW'(sb[c].size())) begin
                    n_fail++;
                    $display("FAIL rand_occ ch%0d cyc%0d: got %0d want %0d",
                             c, cyc, occupancy[c], sb[c].size());
                end
                if (out_valid[c] && out_ready[c]) begin
                    n_tests++;
                    if (sb[c].size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_spurious ch%0d cyc%0d: got %h want nothing",
                                 c, cyc, out_data[c]);
                    end else begin
                        exp_w = sb[c].pop_front();
                        if (out_data[c] !== exp_w) begin
                            n_fail++;
                            $display("FAIL rand_data ch%0d cyc%0d: got %h want %h",
                                     c, cyc, out_data[c], exp_w);
                        end
                    end
                end
                if (in_valid[c] && in_ready[c]) sb[c].push_back(in_data[c]);
            end
            tick();
        end
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (sb[c].size() != 0) begin
                n_fail++;
                $display("FAIL rand_loss ch%0d: %0d words never emerged want 0",
                         c, sb[c].size());
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        bit hit;
        hit = 1'b0;
        do_reset();
        out_ready   = '1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h77;
        for (n = 0; n < 70000; n++) begin
            #1;
            if (xfer_count[0] === 16'hFFFE) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!hit || n != 65534 + D) begin
            n_fail++;
            $display("FAIL wrap_reach: reached=%0d after %0d cycles want 1 after %0d",
                     hit, n, 65534 + D);
        end
        tick();
        n_tests++;
        if (xfer_count[0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_ffff: got %h want ffff", xfer_count[0]);
        end
        tick();
        n_tests++;
        if (xfer_count[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h want 0000", xfer_count[0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_flush();
        test_rst_midstream();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
